// File: rtl/fp32_booth_multiplier.sv
// Iterative radix-4 Booth IEEE-754 single-precision multiplier, round-to-nearest-even.
// Optional FP32_MUL_EARLY_OUT_EN: special-operand results bypass MUL/ROUND (2-cycle latency).
module fp32_booth_multiplier #(
    parameter int EXP_BIAS = 127,
    parameter int ITERS    = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] product,
    output logic [3:0]  flags
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, MUL, ROUND, SPECIAL} state_t;

    state_t             state, state_d;
    logic [CW-1:0]      cnt;
    logic               sign_q;
    logic signed [9:0]  esum_q;
    logic [23:0]        mcand_q;
    logic [26:0]        mplier_q;
    logic signed [25:0] acc_q;
    logic [25:0]        prod_lo_q;
    logic               spec_q;
    logic [31:0]        spec_res_q;
    logic [3:0]         spec_flg_q;

    logic accept;
    assign busy   = (state != IDLE) || result_valid;
    assign accept = (state == IDLE) && start && !result_valid;

    // Operand unpack and special-operand classification
    logic [7:0]  a_exp, b_exp;
    logic        sign_in, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic        spec_in;
    logic [31:0] spec_res;
    logic [3:0]  spec_flg;

    assign a_exp   = a[30:23];
    assign b_exp   = b[30:23];
    assign sign_in = a[31] ^ b[31];
    assign a_nan   = (&a_exp) && (|a[22:0]);
    assign b_nan   = (&b_exp) && (|b[22:0]);
    assign a_snan  = a_nan && !a[22];
    assign b_snan  = b_nan && !b[22];
    assign a_inf   = (&a_exp) && !(|a[22:0]);
    assign b_inf   = (&b_exp) && !(|b[22:0]);
    assign a_zero  = (a_exp == 8'h00);
    assign b_zero  = (b_exp == 8'h00);

    always_comb begin
        spec_in  = 1'b1;
        spec_res = '0;
        spec_flg = '0;
        if (a_nan || b_nan) begin
            spec_res = 32'h7FC0_0000;
            spec_flg = {a_snan || b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res = 32'h7FC0_0000;
            spec_flg = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_res = {sign_in, 8'hFF, 23'h0};
        end else if (a_zero || b_zero) begin
            spec_res = {sign_in, 31'h0};
        end else begin
            spec_in = 1'b0;
        end
    end

    // Booth digit from {b[2i+1], b[2i], b[2i-1]}
    logic signed [25:0] m1, m2, addend, sum;
    assign m1 = {2'b00, mcand_q};
    assign m2 = {1'b0, mcand_q, 1'b0};

    always_comb begin
        addend = '0;
        unique case (mplier_q[2:0])
            3'b001, 3'b010: addend = m1;
            3'b011:         addend = m2;
            3'b100:         addend = -m2;
            3'b101, 3'b110: addend = -m1;
            default:        addend = '0;
        endcase
        sum = acc_q + addend;
    end

    // Normalize and round the finished 48-bit product
    logic [47:0]       p;
    logic [23:0]       mant;
    logic [22:0]       frac;
    logic              g, r, s, up, inexact;
    logic signed [9:0] e;
    logic [31:0]       rnd_res;
    logic [3:0]        rnd_flg;

    assign p = {acc_q[21:0], prod_lo_q};

    always_comb begin
        if (p[47]) begin
            mant = p[47:24];
            g    = p[23];
            r    = p[22];
            s    = |p[21:0];
            e    = esum_q + 10'sd1;
        end else begin
            mant = p[46:23];
            g    = p[22];
            r    = p[21];
            s    = |p[20:0];
            e    = esum_q;
        end
        up      = g && (r || s || mant[0]);
        inexact = g || r || s;
        // An all-ones mantissa that rounds up wraps frac to zero and bumps the exponent
        frac    = mant[22:0] + {22'h0, up};
        if (up && (&mant))
            e = e + 10'sd1;
        if (e >= 10'sd255) begin
            rnd_res = {sign_q, 8'hFF, 23'h0};
            rnd_flg = 4'b0101;
        end else if (e <= 10'sd0) begin
            rnd_res = {sign_q, 31'h0};
            rnd_flg = 4'b0011;
        end else begin
            rnd_res = {sign_q, e[7:0], frac};
            rnd_flg = {3'b000, inexact};
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
`ifdef FP32_MUL_EARLY_OUT_EN
                    state_d = spec_in ? SPECIAL : MUL;
`else
                    state_d = MUL;
`endif
                end
            end
            MUL:     if (cnt == CW'(ITERS - 1)) state_d = ROUND;
            ROUND:   state_d = IDLE;
            SPECIAL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
            product      <= '0;
            flags        <= '0;
            sign_q       <= 1'b0;
            esum_q       <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            prod_lo_q    <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flg_q   <= '0;
        end else begin
            state        <= state_d;
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        sign_q     <= sign_in;
                        esum_q     <= 10'({2'b00, a_exp} + {2'b00, b_exp}) - 10'(EXP_BIAS);
                        mcand_q    <= a_zero ? 24'h0 : {1'b1, a[22:0]};
                        mplier_q   <= {2'b00, (b_zero ? 24'h0 : {1'b1, b[22:0]}), 1'b0};
                        acc_q      <= '0;
                        prod_lo_q  <= '0;
                        spec_q     <= spec_in;
                        spec_res_q <= spec_res;
                        spec_flg_q <= spec_flg;
                    end
                end
                MUL: begin
                    acc_q     <= sum >>> 2;
                    prod_lo_q <= {sum[1:0], prod_lo_q[25:2]};
                    mplier_q  <= mplier_q >> 2;
                    cnt       <= cnt + CW'(1);
                end
                ROUND: begin
                    product      <= spec_q ? spec_res_q : rnd_res;
                    flags        <= spec_q ? spec_flg_q : rnd_flg;
                    result_valid <= 1'b1;
                end
                SPECIAL: begin
                    product      <= spec_res_q;
                    flags        <= spec_flg_q;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_booth_multiplier.sv
// Scoreboard bench for fp32_booth_multiplier: directed vectors with hand-computed results.
module tb_fp32_booth_multiplier;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic        busy, result_valid;
    logic [31:0] product;
    logic [3:0]  flags;

`ifdef FP32_MUL_EARLY_OUT_EN
    localparam int unsigned SPEC_LAT = 1;
`else
    localparam int unsigned SPEC_LAT = 14;
`endif
    localparam int unsigned NORM_LAT = 14;

    fp32_booth_multiplier #(.EXP_BIAS(127), .ITERS(13)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .result_valid(result_valid), .product(product), .flags(flags)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] p;
        logic [3:0]  f;
        int unsigned when;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [3:0]  f;
        bit          sp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_idle = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (chk_idle) begin
            chk("busy_after_valid", {31'h0, busy}, 32'h0);
            chk_idle = 1'b0;
        end
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got product %h, required no result (cycle %0d)", product, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("product", product, mon_e.p);
                chk("flags", {28'h0, flags}, {28'h0, mon_e.f});
                chk("latency", cyc, mon_e.when);
                chk("busy_in_valid", {31'h0, busy}, 32'h1);
            end
            chk_idle = 1'b1;
        end
    end

    task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ep, input logic [3:0] ef,
                         input bit sp, input bit push);
        int unsigned w = 0;
        exp_t x;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: busy still 1 after %0d cycles, required 0", w);
            return;
        end
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_at_accept", {31'h0, busy}, 32'h1);
        if (push) begin
            x.p = ep;
            x.f = ef;
            x.when = cyc + (sp ? SPEC_LAT : NORM_LAT);
            sb_q.push_back(x);
        end
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned w = 0;
        while (sb_q.size() != 0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        vecs.push_back('{32'h40400000, 32'h40200000, 32'h40F00000, 4'h0, 1'b0}); // 3.0*2.5
        vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1, 1'b0}); // sticky only
        vecs.push_back('{32'hC0000000, 32'h3F000000, 32'hBF800000, 4'h0, 1'b0}); // -2*0.5
        vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5, 1'b0}); // overflow
        vecs.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 4'h3, 1'b0}); // underflow
        vecs.push_back('{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1, 1'b0}); // tie, odd -> up
        vecs.push_back('{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1, 1'b0}); // tie, even -> stay
        vecs.push_back('{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'h1, 1'b0}); // rounding carry-out
        vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8, 1'b1}); // inf*0
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, 1'b1}); // -inf*2
        vecs.push_back('{32'h80000000, 32'h40400000, 32'h80000000, 4'h0, 1'b1}); // -0*3
        vecs.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 4'h0, 1'b1}); // denormal flushed
        vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0, 1'b1}); // qNaN
        vecs.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8, 1'b1}); // sNaN

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_valid", {31'h0, result_valid}, 32'h0);
        chk("reset_product", product, 32'h0);
        chk("reset_flags", {28'h0, flags}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            issue(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].f, vecs[i].sp, 1'b1);
        drain(100);

        // Second start in the middle of an operation must be dropped
        issue(32'h40400000, 32'h40200000, 32'h40F00000, 4'h0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        a = 32'h40000000;
        b = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(100);
        repeat (20) @(negedge clk);

        // Reset during MUL aborts the operation and clears the outputs
        issue(32'h3F800001, 32'h3F800001, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_valid", {31'h0, result_valid}, 32'h0);
        chk("abort_product", product, 32'h0);
        chk("abort_flags", {28'h0, flags}, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        issue(32'hC0000000, 32'h3F000000, 32'hBF800000, 4'h0, 1'b0, 1'b1);
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
